draw_cmd_arbiter: RTL

- Shares the single VGA draw-command port (32-bit cell/rectangle commands) between two independent command producers.
- Requester A is the snake game core; requester B is a secondary overlay such as the score/text painter.
- Each requester pushes into its own small FIFO without backpressure. A registered output stage presents one command at a time to the draw engine with a valid/ready handshake.
- Arbitration is round-robin by default, with fixed-priority mode selectable by parameter.

---
 rtl/draw_cmd_arbiter_if.sv | 32 +++
 rtl/draw_cmd_arbiter.sv | 119 +++++++++++
 2 files changed

// File: rtl/draw_cmd_arbiter_if.sv
// Draw-command bus between two producers, the arbiter and the VGA draw engine.
// The arbiter uses the slave view; the master view belongs to whatever drives the producers.
interface draw_cmd_arbiter_if #(
   parameter int CMD_WIDTH = 32,
   parameter int FIFO_AW   = 2
);
   logic                 enb;
   logic [CMD_WIDTH-1:0] a_cmd;
   logic                 a_vld;
   logic [CMD_WIDTH-1:0] b_cmd;
   logic                 b_vld;
   logic [CMD_WIDTH-1:0] out_cmd;
   logic                 out_vld;
   logic                 out_rdy;
   logic                 out_src;
   logic [FIFO_AW:0]     a_level;
   logic [FIFO_AW:0]     b_level;
   logic                 a_ovf;
   logic                 b_ovf;
   logic                 ovf_clr;
   logic                 idle;

   modport slave (
      input  enb, a_cmd, a_vld, b_cmd, b_vld, out_rdy, ovf_clr,
      output out_cmd, out_vld, out_src, a_level, b_level, a_ovf, b_ovf, idle
   );

   modport master (
      output enb, a_cmd, a_vld, b_cmd, b_vld, out_rdy, ovf_clr,
      input  out_cmd, out_vld, out_src, a_level, b_level, a_ovf, b_ovf, idle
   );
endinterface

// File: rtl/draw_cmd_arbiter.sv
// Two push-only command FIFOs (A = game core, B = overlay) arbitrated into one
// registered valid/ready output stage feeding the VGA draw engine.
module draw_cmd_arbiter #(
   parameter int CMD_WIDTH = 32,
   parameter int FIFO_AW   = 2,
   parameter int PRIO_MODE = 0
) (
   input  logic                clk,
   input  logic                rst,
   draw_cmd_arbiter_if.slave   bus
);
   localparam int               DEPTH    = 1 << FIFO_AW;
   localparam logic [FIFO_AW:0] FULL_LVL = (FIFO_AW + 1)'(DEPTH);

   logic [CMD_WIDTH-1:0] w_cmd_in [2];
   logic [CMD_WIDTH-1:0] w_head   [2];
   logic [FIFO_AW:0]     w_level  [2];
   logic [1:0]           w_vld_in;
   logic [1:0]           w_nonempty;
   logic [1:0]           w_pop;
   logic [1:0]           w_ovf;
   logic                 w_free;
   logic                 w_load;
   logic                 w_grant;

   logic [CMD_WIDTH-1:0] r_out_cmd;
   logic                 r_out_vld;
   logic                 r_out_src;
   logic                 r_last_grant;

   assign w_cmd_in[0] = bus.a_cmd;
   assign w_cmd_in[1] = bus.b_cmd;
   assign w_vld_in    = {bus.b_vld, bus.a_vld};

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_fifo
         logic [CMD_WIDTH-1:0] r_mem [DEPTH];
         logic [FIFO_AW-1:0]   r_wr_ptr;
         logic [FIFO_AW-1:0]   r_rd_ptr;
         logic [FIFO_AW:0]     r_level;
         logic                 r_ovf;
         logic                 w_full;
         logic                 w_push;
         logic                 w_drop;

         // A full FIFO still takes a push when its head leaves on the same edge.
         assign w_full = (r_level == FULL_LVL);
         assign w_push = w_vld_in[gi] && (!w_full || w_pop[gi]);
         assign w_drop = w_vld_in[gi] && w_full && !w_pop[gi];

         always_ff @(posedge clk) begin
            if (w_push) begin
               r_mem[r_wr_ptr] <= w_cmd_in[gi];
            end
         end

         always_ff @(posedge clk) begin
            if (rst) begin
               r_wr_ptr <= '0;
               r_rd_ptr <= '0;
               r_level  <= '0;
               r_ovf    <= 1'b0;
            end else begin
               if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
               if (w_pop[gi]) r_rd_ptr <= r_rd_ptr + 1'b1;
               if (w_push && !w_pop[gi]) r_level <= r_level + 1'b1;
               else if (!w_push && w_pop[gi]) r_level <= r_level - 1'b1;
               // A fresh overflow outranks a coincident clear.
               if (w_drop) r_ovf <= 1'b1;
               else if (bus.ovf_clr) r_ovf <= 1'b0;
            end
         end

         assign w_head[gi]     = r_mem[r_rd_ptr];
         assign w_level[gi]    = r_level;
         assign w_nonempty[gi] = |r_level;
         assign w_ovf[gi]      = r_ovf;
      end
   endgenerate

   always_comb begin
      w_grant = 1'b0;
      if (w_nonempty == 2'b11) begin
         w_grant = (PRIO_MODE != 0) ? 1'b0 : ~r_last_grant;
      end else if (w_nonempty == 2'b10) begin
         w_grant = 1'b1;
      end
   end

   assign w_free = !r_out_vld || bus.out_rdy;
   assign w_load = w_free && bus.enb && (|w_nonempty);
   assign w_pop  = {w_load && w_grant, w_load && !w_grant};

   always_ff @(posedge clk) begin
      if (rst) begin
         r_out_cmd    <= '0;
         r_out_vld    <= 1'b0;
         r_out_src    <= 1'b0;
         r_last_grant <= 1'b1;
      end else if (w_load) begin
         r_out_cmd    <= w_head[w_grant];
         r_out_vld    <= 1'b1;
         r_out_src    <= w_grant;
         r_last_grant <= w_grant;
      end else if (w_free) begin
         r_out_vld    <= 1'b0;
      end
   end

   assign bus.out_cmd = r_out_cmd;
   assign bus.out_vld = r_out_vld;
   assign bus.out_src = r_out_src;
   assign bus.a_level = w_level[0];
   assign bus.b_level = w_level[1];
   assign bus.a_ovf   = w_ovf[0];
   assign bus.b_ovf   = w_ovf[1];
   assign bus.idle    = (w_level[0] == '0) && (w_level[1] == '0) && !r_out_vld;
endmodule
